axis_ringmod_multi: RTL and testbench

Parametrised multi-channel ring modulator on the AXI-Stream audio path, successor to the fixed-width single-carrier ring modulator. It multiplies each PCM sample by a selectable carrier (triangle/square/saw/optional sine) from a shared phase accumulator. The result is blended with the dry signal by a wet/dry mix. The block is fully pipelined at one beat per cycle, and all channels of one frame see the same carrier value.

---
 rtl/ringmod_pkg.sv | 27 ++
 rtl/ringmod_carrier_nco.sv | 80 ++++++++
 rtl/axis_ringmod_multi.sv | 159 +++++++++++++++
 tb/tb_axis_ringmod_multi.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ringmod_pkg.sv
// Shared types and constants for the multi-channel ring modulator.
// The sine table generator is only referenced when RINGMOD_SINE_LUT_EN is defined.
package ringmod_pkg;

  typedef enum logic [1:0] {
    WAVE_TRI = 2'b00,
    WAVE_SQR = 2'b01,
    WAVE_SAW = 2'b10,
    WAVE_SIN = 2'b11
  } wave_t;

  localparam int MIX_W     = 9;
  localparam int MIX_SHIFT = 8;
  localparam int MIX_FULL  = 256;
  localparam int SIN_DEPTH = 1024;

  // round((2^(pw-1)-1) * sin(2*pi*idx/SIN_DEPTH)), evaluated at elaboration
  function automatic int sine_val(input int idx, input int pw);
    real amp;
    real x;
    amp = (2.0 ** (pw - 1)) - 1.0;
    x = amp * $sin(2.0 * 3.141592653589793 * real'(idx) / real'(SIN_DEPTH));
    if (x >= 0.0) return int'($floor(x + 0.5));
    return -int'($floor(-x + 0.5));
  endfunction

endpackage

// File: rtl/ringmod_carrier_nco.sv
// Frame-rate phase accumulator and waveform decode for the ring modulator.
// Sine ROM is built only when RINGMOD_SINE_LUT_EN is defined.
module ringmod_carrier_nco
  import ringmod_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int NUM_CH  = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               accept,
  input  logic               last,
  input  logic               enable,
  input  logic [1:0]         wave,
  input  logic [PHASE_W-1:0] inc,
  output logic [PHASE_W-1:0] carrier
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

  logic [PHASE_W-1:0] phase;
  logic [CH_W-1:0]    ch_idx;
  logic               frame_end;
  wave_t              wsel;
  logic [PHASE_W-2:0] tri_t;
  logic [PHASE_W-1:0] tri_c;
  logic [PHASE_W-1:0] sqr_c;
  logic [PHASE_W-1:0] saw_c;
  logic [PHASE_W-1:0] car_next;

  assign wsel      = wave_t'(wave);
  assign frame_end = accept && (last || (ch_idx == CH_LAST));

  assign tri_t = phase[PHASE_W-1] ? ~phase[PHASE_W-2:0]
                                  : phase[PHASE_W-2:0];
  assign tri_c = {~tri_t[PHASE_W-2], tri_t[PHASE_W-3:0], 1'b0};
  assign sqr_c = phase[PHASE_W-1] ? {1'b1, {(PHASE_W-1){1'b0}}}
                                  : {1'b0, {(PHASE_W-1){1'b1}}};
  assign saw_c = {~phase[PHASE_W-1], phase[PHASE_W-2:0]};

`ifdef RINGMOD_SINE_LUT_EN
  localparam int SIN_AW = $clog2(SIN_DEPTH);
  logic [PHASE_W-1:0] sin_rom [SIN_DEPTH];
  logic [PHASE_W-1:0] sin_c;
  for (genvar i = 0; i < SIN_DEPTH; i++) begin : g_rom
    assign sin_rom[i] = PHASE_W'(sine_val(i, PHASE_W));
  end
  assign sin_c = sin_rom[phase[PHASE_W-1 -: SIN_AW]];
`endif

  // waveform select from the current frame-start phase
  always_comb begin
    car_next = tri_c;
    unique case (wsel)
      WAVE_TRI: car_next = tri_c;
      WAVE_SQR: car_next = sqr_c;
      WAVE_SAW: car_next = saw_c;
`ifdef RINGMOD_SINE_LUT_EN
      WAVE_SIN: car_next = sin_c;
`else
      WAVE_SIN: car_next = tri_c;
`endif
    endcase
  end

  // channel counter, frame-end phase advance and S1 carrier register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      phase   <= '0;
      ch_idx  <= '0;
      carrier <= '0;
    end else if (accept) begin
      carrier <= car_next;
      ch_idx  <= frame_end ? '0 : ch_idx + 1'b1;
      if (frame_end && enable) phase <= phase + inc;
    end
  end

endmodule

// File: rtl/axis_ringmod_multi.sv
// Multi-channel AXI-Stream ring modulator with wet/dry mix, 3-stage pipeline.
// Optional sine carrier enabled by defining RINGMOD_SINE_LUT_EN.
module axis_ringmod_multi
  import ringmod_pkg::*;
#(
  parameter int SAMPLE_W = 24,
  parameter int WORD_W   = 32,
  parameter int PHASE_W  = 16,
  parameter int NUM_CH   = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ringmod_enable,
  input  logic [1:0]         ringmod_wave,
  input  logic [PHASE_W-1:0] ringmod_inc,
  input  logic [MIX_W-1:0]   ringmod_mix,
  input  logic [WORD_W-1:0]  s_axis_data,
  input  logic               s_axis_valid,
  output logic               s_axis_ready,
  input  logic               s_axis_last,
  output logic [WORD_W-1:0]  m_axis_data,
  output logic               m_axis_valid,
  input  logic               m_axis_ready,
  output logic               m_axis_last
);

  localparam int PROD_W = SAMPLE_W + PHASE_W;
  localparam int MIXA_W = SAMPLE_W + 10;
  localparam logic [MIX_W-1:0] MIX_MAX = MIX_W'(MIX_FULL);
  localparam logic [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic adv;
  logic accept;
  logic [MIX_W-1:0] mix_clamp;

  logic                s1_valid;
  logic                s1_last;
  logic                s1_en;
  logic [MIX_W-1:0]    s1_mix;
  logic [WORD_W-1:0]   s1_word;
  logic [PHASE_W-1:0]  carrier;

  logic                s2_valid;
  logic                s2_last;
  logic                s2_en;
  logic [MIX_W-1:0]    s2_mix;
  logic [WORD_W-1:0]   s2_word;
  logic [SAMPLE_W-1:0] s2_wet;

  assign adv          = !m_axis_valid || m_axis_ready;
  assign s_axis_ready = adv && resetn;
  assign accept       = s_axis_valid && s_axis_ready;
  assign mix_clamp    = (ringmod_mix > MIX_MAX) ? MIX_MAX : ringmod_mix;

  ringmod_carrier_nco #(
    .PHASE_W (PHASE_W),
    .NUM_CH  (NUM_CH)
  ) u_nco (
    .clk     (clk),
    .resetn  (resetn),
    .accept  (accept),
    .last    (s_axis_last),
    .enable  (ringmod_enable),
    .wave    (ringmod_wave),
    .inc     (ringmod_inc),
    .carrier (carrier)
  );

  // S2 datapath: full-width product, rescale, saturate
  logic signed [SAMPLE_W-1:0] s1_smp;
  logic signed [PHASE_W-1:0]  s1_car;
  logic signed [PROD_W-1:0]   prod;
  logic signed [PROD_W-1:0]   prod_sh;
  logic [PROD_W-SAMPLE_W:0]   prod_top;
  logic [SAMPLE_W-1:0]        wet_next;

  assign s1_smp   = s1_word[SAMPLE_W-1:0];
  assign s1_car   = carrier;
  assign prod     = s1_smp * s1_car;
  assign prod_sh  = prod >>> (PHASE_W - 1);
  assign prod_top = prod_sh[PROD_W-1:SAMPLE_W-1];
  assign wet_next = ((&prod_top) || !(|prod_top))
                  ? prod_sh[SAMPLE_W-1:0]
                  : (prod_sh[PROD_W-1] ? S_MIN : S_MAX);

  // S3 datapath: dry + (wet - dry) * mix / 256, saturate
  logic signed [MIXA_W-1:0] dry_x;
  logic signed [MIXA_W-1:0] wet_x;
  logic signed [MIXA_W-1:0] mix_x;
  logic signed [MIXA_W-1:0] diff;
  logic signed [MIXA_W-1:0] scaled;
  logic signed [MIXA_W-1:0] sum;
  logic [MIXA_W-SAMPLE_W:0] sum_top;
  logic [SAMPLE_W-1:0]      mix_out;

  assign dry_x   = {{(MIXA_W-SAMPLE_W){s2_word[SAMPLE_W-1]}},
                    s2_word[SAMPLE_W-1:0]};
  assign wet_x   = {{(MIXA_W-SAMPLE_W){s2_wet[SAMPLE_W-1]}}, s2_wet};
  assign mix_x   = {{(MIXA_W-MIX_W){1'b0}}, s2_mix};
  assign diff    = wet_x - dry_x;
  assign scaled  = (diff * mix_x) >>> MIX_SHIFT;
  assign sum     = dry_x + scaled;
  assign sum_top = sum[MIXA_W-1:SAMPLE_W-1];
  assign mix_out = ((&sum_top) || !(|sum_top))
                 ? sum[SAMPLE_W-1:0]
                 : (sum[MIXA_W-1] ? S_MIN : S_MAX);

  // S1: capture beat and its controls
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_en    <= 1'b0;
      s1_mix   <= '0;
      s1_word  <= '0;
    end else if (adv) begin
      s1_valid <= s_axis_valid;
      s1_last  <= s_axis_last;
      s1_en    <= ringmod_enable;
      s1_mix   <= mix_clamp;
      s1_word  <= s_axis_data;
    end
  end

  // S2: register saturated wet sample alongside the dry word
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_en    <= 1'b0;
      s2_mix   <= '0;
      s2_word  <= '0;
      s2_wet   <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_en    <= s1_en;
      s2_mix   <= s1_mix;
      s2_word  <= s1_word;
      s2_wet   <= wet_next;
    end
  end

  // S3: output register, bypass passes the word untouched
  always_ff @(posedge clk) begin
    if (!resetn) begin
      m_axis_valid <= 1'b0;
      m_axis_last  <= 1'b0;
      m_axis_data  <= '0;
    end else if (adv) begin
      m_axis_valid <= s2_valid;
      m_axis_last  <= s2_last;
      m_axis_data  <= s2_en ? {s2_word[WORD_W-1:SAMPLE_W], mix_out}
                            : s2_word;
    end
  end

endmodule

// File: tb/tb_axis_ringmod_multi.sv
// Self-checking bench for axis_ringmod_multi (default parameters).
// Reference model works on integer phase/sample arithmetic.
module tb_axis_ringmod_multi;

  localparam int NUM_CH = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ringmod_enable;
  logic [1:0]  ringmod_wave;
  logic [15:0] ringmod_inc;
  logic [8:0]  ringmod_mix;
  logic [31:0] s_axis_data;
  logic        s_axis_valid;
  logic        s_axis_ready;
  logic        s_axis_last;
  logic [31:0] m_axis_data;
  logic        m_axis_valid;
  logic        m_axis_ready;
  logic        m_axis_last;

  int n_vec = 0;
  int n_err = 0;
  longint m_phase = 0;
  int m_ch = 0;
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];

  axis_ringmod_multi dut (
    .clk            (clk),
    .resetn         (resetn),
    .ringmod_enable (ringmod_enable),
    .ringmod_wave   (ringmod_wave),
    .ringmod_inc    (ringmod_inc),
    .ringmod_mix    (ringmod_mix),
    .s_axis_data    (s_axis_data),
    .s_axis_valid   (s_axis_valid),
    .s_axis_ready   (s_axis_ready),
    .s_axis_last    (s_axis_last),
    .m_axis_data    (m_axis_data),
    .m_axis_valid   (m_axis_valid),
    .m_axis_ready   (m_axis_ready),
    .m_axis_last    (m_axis_last)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (resetn && m_axis_valid && m_axis_ready)
      got_q.push_back({m_axis_last, m_axis_data});

  function automatic longint sat24(input longint v);
    if (v > 8388607) return 8388607;
    if (v < -8388608) return -8388608;
    return v;
  endfunction

  function automatic longint car_of(input longint p, input logic [1:0] w);
    longint t;
    real x;
    case (w)
      2'd1: return (p < 32768) ? 32767 : -32768;
      2'd2: return p - 32768;
`ifdef RINGMOD_SINE_LUT_EN
      2'd3: begin
        x = 32767.0 * $sin(2.0 * 3.141592653589793 * real'(p / 64) / 1024.0);
        if (x >= 0.0) return longint'($floor(x + 0.5));
        return -longint'($floor(-x + 0.5));
      end
`endif
      default: begin
        x = 0.0;
        t = (p < 32768) ? p : 65535 - p;
        return 2 * t - 32768;
      end
    endcase
  endfunction

  task automatic model_accept();
    logic [32:0] e;
    logic [23:0] ov;
    longint smp, c, wet, mx, o;
    bit fe;
    if (ringmod_enable) begin
      smp = s_axis_data[23:0];
      if (smp >= 8388608) smp -= 16777216;
      c = car_of(m_phase, ringmod_wave);
      wet = sat24((smp * c) >>> 15);
      mx = (ringmod_mix > 9'd256) ? 256 : ringmod_mix;
      o = sat24(smp + (((wet - smp) * mx) >>> 8));
      ov = o[23:0];
      e = {s_axis_last, s_axis_data[31:24], ov};
    end else begin
      e = {s_axis_last, s_axis_data};
    end
    exp_q.push_back(e);
    fe = s_axis_last || (m_ch == NUM_CH - 1);
    m_ch = fe ? 0 : m_ch + 1;
    if (fe && ringmod_enable) m_phase = (m_phase + ringmod_inc) % 65536;
  endtask

  task automatic send(input logic [31:0] w, input logic l);
    int n;
    s_axis_data = w;
    s_axis_last = l;
    s_axis_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_axis_ready && n < 300);
    if (!s_axis_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: ready=%b want 1", s_axis_ready);
    end else begin
      model_accept();
    end
    @(posedge clk);
    #1;
    s_axis_valid = 1'b0;
  endtask

  task automatic wait_out(input int cnt);
    int n;
    n = 0;
    while (got_q.size() < cnt && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (got_q.size() < cnt) begin
      n_vec++;
      n_err++;
      $display("FAIL out_timeout: got %0d beats want %0d", got_q.size(), cnt);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    s_axis_valid = 1'b0;
    s_axis_last = 1'b0;
    m_axis_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    exp_q.delete();
    got_q.delete();
    m_phase = 0;
    m_ch = 0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (m_axis_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_valid: got %b want 0", m_axis_valid);
    end
    n_vec++;
    if (m_axis_data !== 32'h0) begin
      n_err++;
      $display("FAIL rst_data: got %h want 0", m_axis_data);
    end
    n_vec++;
    if (m_axis_last !== 1'b0) begin
      n_err++;
      $display("FAIL rst_last: got %b want 0", m_axis_last);
    end
    n_vec++;
    if (s_axis_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_ready: got %b want 0", s_axis_ready);
    end
  endtask

  task automatic test_bypass();
    int n, lat;
    do_reset();
    ringmod_enable = 1'b0;
    ringmod_wave = 2'd1;
    ringmod_mix = 9'd128;
    ringmod_inc = 16'h1234;
    s_axis_data = 32'hAB123456;
    s_axis_last = 1'b1;
    s_axis_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_axis_ready && n < 50);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      s_axis_valid = 1'b0;
      if (m_axis_valid) break;
    end
    n_vec++;
    if (lat !== 3) begin
      n_err++;
      $display("FAIL bypass_latency: got %0d want 3", lat);
    end
    n_vec++;
    if (m_axis_data !== 32'hAB123456) begin
      n_err++;
      $display("FAIL bypass_data: got %h want AB123456", m_axis_data);
    end
    n_vec++;
    if (m_axis_last !== 1'b1) begin
      n_err++;
      $display("FAIL bypass_last: got %b want 1", m_axis_last);
    end
  endtask

  task automatic test_square();
    do_reset();
    ringmod_enable = 1'b1;
    ringmod_wave = 2'd1;
    ringmod_mix = 9'd256;
    ringmod_inc = 16'h0;
    send(32'h00400000, 1'b1);
    send(32'h00400000, 1'b1);
    wait_out(2);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (got_q[i] !== {1'b1, 32'h003FFF80}) begin
        n_err++;
        $display("FAIL square_wet[%0d]: got %h want 1003FFF80", i, got_q[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [32:0] want [3];
    want[0] = {1'b1, 32'h003FFF80};
    want[1] = {1'b1, 32'h007FFFFF};
    want[2] = {1'b1, 32'h00C00000};
    do_reset();
    ringmod_enable = 1'b1;
    ringmod_wave = 2'd1;
    ringmod_mix = 9'd256;
    ringmod_inc = 16'h8000;
    send(32'h00400000, 1'b1);
    ringmod_inc = 16'h0;
    send(32'h00800000, 1'b1);
    send(32'h00400000, 1'b1);
    wait_out(3);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (got_q[i] !== want[i]) begin
        n_err++;
        $display("FAIL saturation[%0d]: got %h want %h", i, got_q[i], want[i]);
      end
    end
  endtask

  task automatic test_mix();
    logic [32:0] want [4];
    want[0] = {1'b1, 32'h00400000};
    want[1] = {1'b1, 32'h003FFFC0};
    want[2] = {1'b1, 32'h003FFF80};
    want[3] = {1'b1, 32'hA53FFF80};
    do_reset();
    ringmod_enable = 1'b1;
    ringmod_wave = 2'd1;
    ringmod_inc = 16'h0;
    ringmod_mix = 9'd0;
    send(32'h00400000, 1'b1);
    ringmod_mix = 9'd128;
    send(32'h00400000, 1'b1);
    ringmod_mix = 9'd300;
    send(32'h00400000, 1'b1);
    ringmod_mix = 9'd256;
    send(32'hA5400000, 1'b1);
    wait_out(4);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (got_q[i] !== want[i]) begin
        n_err++;
        $display("FAIL mix[%0d]: got %h want %h", i, got_q[i], want[i]);
      end
    end
  endtask

  task automatic test_frame_phase();
    logic [32:0] want [6];
    want[0] = {1'b0, 32'h00C00000};
    want[1] = {1'b0, 32'h00C00000};
    want[2] = {1'b0, 32'h00C80000};
    want[3] = {1'b0, 32'h00C80000};
    want[4] = {1'b1, 32'h00D00000};
    want[5] = {1'b1, 32'h00D80000};
    do_reset();
    ringmod_enable = 1'b1;
    ringmod_wave = 2'd2;
    ringmod_mix = 9'd256;
    ringmod_inc = 16'h1000;
    for (int i = 0; i < 4; i++) send(32'h00400000, 1'b0);
    send(32'h00400000, 1'b1);
    send(32'h00400000, 1'b1);
    wait_out(6);
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (got_q[i] !== want[i]) begin
        n_err++;
        $display("FAIL frame_phase[%0d]: got %h want %h", i, got_q[i], want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] held;
    logic hv;
    do_reset();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          ringmod_enable = 1'($urandom_range(0, 3) != 0);
          ringmod_wave = 2'($urandom_range(0, 3));
          ringmod_mix = 9'($urandom_range(0, 511));
          ringmod_inc = 16'($urandom);
          send($urandom, 1'($urandom_range(0, 2) == 0));
        end
      end
      begin
        m_axis_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        m_axis_ready = 1'b0;
        @(negedge clk);
        held = m_axis_data;
        hv = m_axis_valid;
        for (int c = 0; c < 10; c++) begin
          if (c > 0) @(negedge clk);
          n_vec++;
          if (s_axis_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stall_ready[%0d]: got %b want 0", c, s_axis_ready);
          end
          if (hv) begin
            n_vec++;
            if (m_axis_data !== held) begin
              n_err++;
              $display("FAIL stall_hold[%0d]: got %h want %h", c, m_axis_data, held);
            end
          end
        end
        @(posedge clk);
        for (int c = 0; c < 30; c++) begin
          #1;
          m_axis_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
        end
        #1;
        m_axis_ready = 1'b1;
      end
    join
    wait_out(40);
    n_vec++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL b2b_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ringmod_enable = 1'b1;
    ringmod_wave = 2'd2;
    ringmod_mix = 9'd256;
    ringmod_inc = 16'h1000;
    for (int i = 0; i < 3; i++) send($urandom, 1'b1);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (m_axis_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_valid: got %b want 0", m_axis_valid);
    end
    n_vec++;
    if (s_axis_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_ready: got %b want 0", s_axis_ready);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    exp_q.delete();
    got_q.delete();
    m_phase = 0;
    m_ch = 0;
    ringmod_inc = 16'h0;
    send(32'h00400000, 1'b1);
    wait_out(1);
    repeat (6) @(negedge clk);
    n_vec++;
    if (got_q.size() !== 1) begin
      n_err++;
      $display("FAIL midrst_count: got %0d want 1", got_q.size());
    end
    n_vec++;
    if (got_q[0] !== {1'b1, 32'h00C00000}) begin
      n_err++;
      $display("FAIL midrst_phase: got %h want 100C00000", got_q[0]);
    end
  endtask

  initial begin
    resetn = 1'b0;
    ringmod_enable = 1'b0;
    ringmod_wave = 2'd0;
    ringmod_inc = 16'h0;
    ringmod_mix = 9'd0;
    s_axis_data = 32'h0;
    s_axis_valid = 1'b0;
    s_axis_last = 1'b0;
    m_axis_ready = 1'b1;
    test_reset();
    test_bypass();
    test_square();
    test_saturation();
    test_mix();
    test_frame_phase();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
